// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues single-outstanding fetches
// and presents one instruction per accepted response (NOP bubble otherwise).
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        discard_q, discard_d;
    logic        req;
    logic [31:0] jump_tgt;

    assign jump_tgt    = {jump_addr_i[31:2], 2'b00};
    assign ibus_addr_o = pc_q;
    // Request is masked while reset is asserted even though the state already reads S_REQ.
    assign ibus_req_o  = req && rst_n;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        buf_data_d   = buf_data_q;
        discard_d    = discard_q;
        req          = 1'b0;
        inst_o       = NOP_INST;
        inst_addr_o  = '0;

        case (state_q)
            S_REQ: begin
                req = !hold_i && !jump_en_i;
                if (jump_en_i) begin
                    pc_d = jump_tgt;
                end else if (req && ibus_gnt_i) begin
                    fetch_addr_d = pc_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_WAIT;
                end
            end

            S_WAIT: begin
                if (jump_en_i) begin
                    pc_d = jump_tgt;
                    // A response in the jump cycle is dropped; otherwise drop the one still in flight.
                    if (ibus_rvalid_i) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (ibus_rvalid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (hold_i) begin
                        buf_data_d = ibus_rdata_i;
                        state_d    = S_HELD;
                    end else begin
                        inst_o      = ibus_rdata_i;
                        inst_addr_o = fetch_addr_q;
                        state_d     = S_REQ;
                    end
                end
            end

            S_HELD: begin
                if (jump_en_i) begin
                    pc_d    = jump_tgt;
                    state_d = S_REQ;
                end else if (!hold_i) begin
                    inst_o      = buf_data_q;
                    inst_addr_o = fetch_addr_q;
                    state_d     = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
            buf_data_q   <= '0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            buf_data_q   <= buf_data_d;
            discard_q    <= discard_d;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: cycle-accurate vector table plus a randomised
// grant/response-latency sequence checked through a scoreboard queue.
module tb_ifetch_ctrl;

    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_i        (hold_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] ja;
        logic        hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] einst;
        logic [31:0] eia;
    } vec_t;

    typedef struct {
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] einst;
        logic [31:0] eia;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] ia;
    } pair_t;

    vec_t  vecs[$];
    exp_t  sbq[$];
    pair_t hq[$];
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic jmp, input logic [31:0] ja, input logic hold,
                     input logic gnt, input logic rv, input logic [31:0] rd, input logic ereq,
                     input logic [31:0] eaddr, input logic [31:0] einst, input logic [31:0] eia);
        vec_t t;
        t.rst = rst; t.jmp = jmp; t.ja = ja; t.hold = hold; t.gnt = gnt; t.rv = rv; t.rd = rd;
        t.ereq = ereq; t.eaddr = eaddr; t.einst = einst; t.eia = eia;
        vecs.push_back(t);
    endtask

    initial begin
        exp_t        e;
        pair_t       p;
        logic        busy, busy_before;
        logic [31:0] pend_addr, exp_pc;
        int          lat, nfetch;

        // rst jmp ja hold gnt rv rdata | req addr inst inst_addr
        v(0,0,32'h0,0,0,0,32'h0,            0,32'h0,  N,0);
        v(0,0,32'h0,0,1,0,32'h0,            0,32'h0,  N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h0,  N,0);
        v(1,0,32'h0,0,1,1,32'hA5A5_0000,    0,32'h4,  32'hA5A5_0000,32'h0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h4,  N,0);
        v(1,0,32'h0,0,1,1,32'hA5A5_0004,    0,32'h8,  32'hA5A5_0004,32'h4);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h8,  N,0);
        v(1,0,32'h0,0,1,1,32'hA5A5_0008,    0,32'hC,  32'hA5A5_0008,32'h8);
        v(1,0,32'h0,0,0,0,32'h0,            1,32'hC,  N,0);
        v(1,0,32'h0,0,0,0,32'h0,            1,32'hC,  N,0);
        v(1,0,32'h0,0,0,0,32'h0,            1,32'hC,  N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'hC,  N,0);
        v(1,1,32'h103,0,0,0,32'h0,          0,32'h10, N,0);
        v(1,0,32'h0,0,0,1,32'h1234_5678,    0,32'h100,N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h100,N,0);
        v(1,1,32'h40,0,0,0,32'h0,           0,32'h104,N,0);
        v(1,1,32'hF,0,0,0,32'h0,            0,32'h40, N,0);
        v(1,0,32'h0,0,0,1,32'h9999_9999,    0,32'hC,  N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'hC,  N,0);
        v(1,0,32'h0,0,0,1,32'hA5A5_000C,    0,32'h10, 32'hA5A5_000C,32'hC);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h10, N,0);
        v(1,0,32'h0,1,1,1,32'hDEAD_BEEF,    0,32'h14, N,0);
        v(1,0,32'h0,1,1,0,32'h0,            0,32'h14, N,0);
        v(1,0,32'h0,1,1,0,32'h0,            0,32'h14, N,0);
        v(1,0,32'h0,0,1,0,32'h0,            0,32'h14, 32'hDEAD_BEEF,32'h10);
        v(1,0,32'h0,1,1,0,32'h0,            0,32'h14, N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h14, N,0);
        v(1,1,32'h200,0,0,1,32'h7777_7777,  0,32'h18, N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h200,N,0);
        v(1,0,32'h0,1,0,1,32'hCAFE_F00D,    0,32'h204,N,0);
        v(1,1,32'h200,1,0,0,32'h0,          0,32'h204,N,0);
        v(1,0,32'h0,0,0,0,32'h0,            1,32'h200,N,0);
        v(1,1,32'h300,0,1,0,32'h0,          0,32'h200,N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h300,N,0);
        v(0,0,32'h0,0,1,0,32'h0,            0,32'h0,  N,0);
        v(0,0,32'h0,0,0,1,32'hBAD0_BAD0,    0,32'h0,  N,0);
        v(1,0,32'h0,0,0,1,32'hBAD0_BAD0,    1,32'h0,  N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'h0,  N,0);
        v(1,0,32'h0,0,0,1,32'hA5A5_0000,    0,32'h4,  32'hA5A5_0000,32'h0);
        v(1,1,32'hFFFF_FFFF,0,1,0,32'h0,    0,32'h4,  N,0);
        v(1,0,32'h0,0,1,0,32'h0,            1,32'hFFFF_FFFC,N,0);
        v(1,0,32'h0,0,0,1,32'h1111_2222,    0,32'h0,  32'h1111_2222,32'hFFFF_FFFC);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst_n         = vecs[i].rst;
            jump_en_i     = vecs[i].jmp;
            jump_addr_i   = vecs[i].ja;
            hold_i        = vecs[i].hold;
            ibus_gnt_i    = vecs[i].gnt;
            ibus_rvalid_i = vecs[i].rv;
            ibus_rdata_i  = vecs[i].rd;
            e.ereq = vecs[i].ereq; e.eaddr = vecs[i].eaddr;
            e.einst = vecs[i].einst; e.eia = vecs[i].eia;
            sbq.push_back(e);
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("v%0d req", i),       32'(ibus_req_o), 32'(e.ereq));
            chk($sformatf("v%0d addr", i),      ibus_addr_o,     e.eaddr);
            chk($sformatf("v%0d inst", i),      inst_o,          e.einst);
            chk($sformatf("v%0d inst_addr", i), inst_addr_o,     e.eia);
        end

        // Random grant delay and response latency; sequential PC from 0.
        exp_pc = 32'h0; busy = 1'b0; nfetch = 0; lat = 0; pend_addr = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (nfetch >= 6 && !busy) break;
            @(posedge clk); #1;
            jump_en_i     = 1'b0;
            hold_i        = 1'b0;
            ibus_gnt_i    = (nfetch < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
            if (busy && lat == 0) begin
                ibus_rvalid_i = 1'b1;
                ibus_rdata_i  = pend_addr ^ 32'hC3C3_0000;
                p.inst = pend_addr ^ 32'hC3C3_0000;
                p.ia   = pend_addr;
                hq.push_back(p);
            end else if (busy) begin
                lat--;
            end
            busy_before = busy;
            @(negedge clk);
            chk("seq req",  32'(ibus_req_o), 32'(!busy_before));
            chk("seq addr", ibus_addr_o, exp_pc);
            if (ibus_rvalid_i) begin
                p = hq.pop_front();
                chk("seq inst", inst_o, p.inst);
                chk("seq inst_addr", inst_addr_o, p.ia);
                busy = 1'b0;
            end else begin
                chk("seq nop", inst_o, N);
            end
            if (!busy_before && ibus_gnt_i) begin
                busy      = 1'b1;
                pend_addr = exp_pc;
                exp_pc    = exp_pc + 32'd4;
                lat       = $urandom_range(0, 2);
                nfetch++;
            end
        end
        chk("seq complete", 32'(nfetch), 32'd6);
        chk("seq idle", 32'(busy), 32'd0);
        chk("scoreboard empty", 32'(hq.size() + sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
